// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - universal shift register with automatic multi-shift burst engine
// Idle cycles decode mode; a burst runs burst_len shifts unattended, then pulses done.
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic [WIDTH-1:0] par_in,
  input  logic             burst_start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             burst_dir,
  output logic [WIDTH-1:0] Q,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic             dir, dir_nxt;
  logic             done_q, done_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      Q      <= '0;
      cnt    <= '0;
      dir    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      Q      <= q_nxt;
      cnt    <= cnt_nxt;
      dir    <= dir_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = Q;
    cnt_nxt   = cnt;
    dir_nxt   = dir;
    done_nxt  = done_q;
    // en=0 freezes everything, including an unseen done pulse
    if (en) begin
      done_nxt = 1'b0;
      case (state)
        IDLE: begin
          if (burst_start) begin
            if (burst_len != '0) begin
              state_nxt = BURST;
              cnt_nxt   = burst_len;
              dir_nxt   = burst_dir;
            end else begin
              done_nxt = 1'b1;
            end
          end else begin
            case (mode)
              3'b001:  q_nxt = {Q[WIDTH-2:0], ser_in_l};
              3'b010:  q_nxt = {ser_in_r, Q[WIDTH-1:1]};
              3'b011:  q_nxt = {Q[WIDTH-2:0], Q[WIDTH-1]};
              3'b100:  q_nxt = {Q[0], Q[WIDTH-1:1]};
              3'b101:  q_nxt = par_in;
              3'b110:  q_nxt = '0;
              default: q_nxt = Q;
            endcase
          end
        end
        BURST: begin
          q_nxt   = dir ? {ser_in_r, Q[WIDTH-1:1]} : {Q[WIDTH-2:0], ser_in_l};
          cnt_nxt = cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign ser_out_l = Q[WIDTH-1];
  assign ser_out_r = Q[0];
  assign busy      = (state == BURST);
  assign done      = done_q & en;

endmodule

// File: tb/tb_universal_shift_register.sv
// tb/tb_universal_shift_register.sv - directed scoreboard bench for universal_shift_register
module tb_universal_shift_register;

  localparam int WIDTH = 8;
  localparam int LEN_W = $clog2(WIDTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [2:0]       mode;
  logic             ser_in_l;
  logic             ser_in_r;
  logic [WIDTH-1:0] par_in;
  logic             burst_start;
  logic [LEN_W-1:0] burst_len;
  logic             burst_dir;
  logic [WIDTH-1:0] Q;
  logic             ser_out_l;
  logic             ser_out_r;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] model;

  universal_shift_register #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .ser_in_l(ser_in_l), .ser_in_r(ser_in_r), .par_in(par_in),
    .burst_start(burst_start), .burst_len(burst_len), .burst_dir(burst_dir),
    .Q(Q), .ser_out_l(ser_out_l), .ser_out_r(ser_out_r),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_check(input string tag);
    logic [WIDTH-1:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, Q);
    end else begin
      e = exp_q.pop_front();
      check(tag, {24'd0, Q}, {24'd0, e});
    end
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    mode = 3'b101; par_in = v; exp_q.push_back(v);
    step();
    sb_check("load");
    mode = 3'b000;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 3'b000; ser_in_l = 1'b0; ser_in_r = 1'b0;
    par_in = '0; burst_start = 1'b0; burst_len = '0; burst_dir = 1'b0;
    #2;
    check("reset_q", {24'd0, Q}, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'h0);
    check("reset_done", {31'd0, done}, 32'h0);
    step();
    rst = 1'b0;

    // serial shifts with edge bits
    load(8'h80);
    mode = 3'b001; ser_in_l = 1'b1; exp_q.push_back(8'h01);
    step(); sb_check("shl");
    check("shl_sol", {31'd0, ser_out_l}, 32'h0);
    check("shl_sor", {31'd0, ser_out_r}, 32'h1);
    mode = 3'b010; ser_in_r = 1'b1; exp_q.push_back(8'h80);
    step(); sb_check("shr");
    check("shr_sol", {31'd0, ser_out_l}, 32'h1);
    check("shr_sor", {31'd0, ser_out_r}, 32'h0);
    ser_in_l = 1'b0; ser_in_r = 1'b0;

    // rotates and clear
    load(8'hA5);
    mode = 3'b011; exp_q.push_back(8'h4B); step(); sb_check("rotl");
    mode = 3'b100; exp_q.push_back(8'hA5); step(); sb_check("rotr");
    mode = 3'b111; exp_q.push_back(8'hA5); step(); sb_check("hold111");
    mode = 3'b110; exp_q.push_back(8'h00); step(); sb_check("clear");
    mode = 3'b000;

    // burst of 3 left, mode toggled to clear during burst must be ignored
    load(8'h0F);
    burst_start = 1'b1; burst_len = 3; burst_dir = 1'b0; mode = 3'b001; ser_in_l = 1'b0;
    exp_q.push_back(8'h0F);
    step(); sb_check("b_start");
    check("b_busy0", {31'd0, busy}, 32'h1);
    check("b_done0", {31'd0, done}, 32'h0);
    burst_start = 1'b0; mode = 3'b110;
    exp_q.push_back(8'h1E); step(); sb_check("b_s1");
    check("b_busy1", {31'd0, busy}, 32'h1);
    exp_q.push_back(8'h3C); step(); sb_check("b_s2");
    check("b_busy2", {31'd0, busy}, 32'h1);
    check("b_done2", {31'd0, done}, 32'h0);
    exp_q.push_back(8'h78); step(); sb_check("b_s3");
    check("b_busy3", {31'd0, busy}, 32'h0);
    check("b_done3", {31'd0, done}, 32'h1);
    mode = 3'b000;
    exp_q.push_back(8'h78); step(); sb_check("b_after");
    check("b_done_after", {31'd0, done}, 32'h0);

    // same burst with en low for two cycles after the first shift
    load(8'h0F);
    burst_start = 1'b1; burst_len = 3; burst_dir = 1'b0;
    exp_q.push_back(8'h0F); step(); sb_check("e_start");
    burst_start = 1'b0;
    exp_q.push_back(8'h1E); step(); sb_check("e_s1");
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(8'h1E); step(); sb_check("e_frozen");
      check("e_busy_frozen", {31'd0, busy}, 32'h1);
      check("e_done_frozen", {31'd0, done}, 32'h0);
    end
    en = 1'b1;
    exp_q.push_back(8'h3C); step(); sb_check("e_s2");
    check("e_busy2", {31'd0, busy}, 32'h1);
    exp_q.push_back(8'h78); step(); sb_check("e_s3");
    check("e_busy3", {31'd0, busy}, 32'h0);
    check("e_done3", {31'd0, done}, 32'h1);
    exp_q.push_back(8'h78); step(); sb_check("e_after");
    check("e_done_after", {31'd0, done}, 32'h0);

    // zero-length burst
    load(8'h5A);
    burst_start = 1'b1; burst_len = 0;
    exp_q.push_back(8'h5A); step(); sb_check("z_q");
    check("z_busy", {31'd0, busy}, 32'h0);
    check("z_done", {31'd0, done}, 32'h1);
    burst_start = 1'b0;
    exp_q.push_back(8'h5A); step(); sb_check("z_q2");
    check("z_done2", {31'd0, done}, 32'h0);

    // burst longer than the register, right direction
    load(8'h00);
    model = 8'h00;
    burst_start = 1'b1; burst_len = 10; burst_dir = 1'b1;
    exp_q.push_back(model); step(); sb_check("l_start");
    burst_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ser_in_r = ((i % 3) != 0);
      model = {ser_in_r, model[WIDTH-1:1]};
      exp_q.push_back(model); step(); sb_check("l_shift");
      check("l_busy", {31'd0, busy}, (i < 9) ? 32'h1 : 32'h0);
    end
    check("l_done", {31'd0, done}, 32'h1);
    ser_in_r = 1'b0;

    // async reset mid-burst at Q=3C
    load(8'h0F);
    burst_start = 1'b1; burst_len = 3; burst_dir = 1'b0;
    exp_q.push_back(8'h0F); step(); sb_check("r_start");
    burst_start = 1'b0;
    exp_q.push_back(8'h1E); step(); sb_check("r_s1");
    exp_q.push_back(8'h3C); step(); sb_check("r_s2");
    rst = 1'b1;
    #1;
    check("r_q", {24'd0, Q}, 32'h0);
    check("r_busy", {31'd0, busy}, 32'h0);
    check("r_done", {31'd0, done}, 32'h0);
    #1;
    rst = 1'b0;
    exp_q.push_back(8'h00); step(); sb_check("r_noresume");
    check("r_busy_after", {31'd0, busy}, 32'h0);
    check("r_done_after", {31'd0, done}, 32'h0);

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL sb_drain observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter LEN_W, default $clog2(WIDTH)+1, width of burst_len.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  global enable; low = every register holds.
REQ-006 SHALL have port mode  input  3  operation select, decoded only while idle.
REQ-007 SHALL have port ser_in_l  input  1  serial bit entering Q[0] on left shift.
REQ-008 SHALL have port ser_in_r  input  1  serial bit entering Q[WIDTH-1] on right shift.
REQ-009 SHALL have port par_in  input  WIDTH  parallel load data.
REQ-010 SHALL have port burst_start  input  1  request automatic multi-shift burst.
REQ-011 SHALL have port burst_len  input  LEN_W  number of shifts in burst.
REQ-012 SHALL have port burst_dir  input  1  burst direction: 0 left, 1 right.
REQ-013 SHALL have port Q  output  WIDTH  register contents.
REQ-014 SHALL have port ser_out_l  output  1  equals Q[WIDTH-1], combinational.
REQ-015 SHALL have port ser_out_r  output  1  equals Q[0], combinational.
REQ-016 SHALL have port busy  output  1  high while burst in progress.
REQ-017 SHALL have port done  output  1  one-cycle burst-complete pulse.

Function
REQ-018 SHALL, in IDLE with en=1 and burst_start=0, apply mode: 000 hold; 001 shift left Q<={Q[W-2:0],ser_in_l}; 010 shift right Q<={ser_in_r,Q[W-1:1]}; 011 rotate left; 100 rotate right; 101 load par_in; 110 clear to 0; 111 hold.
REQ-019 SHALL implement FSM states IDLE and BURST plus registered remaining-shift counter of LEN_W bits.
REQ-020 SHALL, in IDLE with en=1, burst_start=1, burst_len!=0: capture burst_len and burst_dir, enter BURST, leave Q unchanged that cycle (mode ignored).
REQ-021 SHALL, in BURST with en=1, perform one shift per cycle in captured direction (left uses ser_in_l, right uses ser_in_r, sampled live) and decrement counter.
REQ-022 SHALL return to IDLE on the edge performing the final shift; exactly burst_len shifts total.
REQ-023 SHALL hold busy high from the cycle after burst start through the cycle before the final-shift edge's successor, i.e. busy=1 exactly while state=BURST.
REQ-024 SHALL assert done (registered) for exactly one cycle immediately after the final shift.
REQ-025 SHALL, in IDLE with en=1, burst_start=1, burst_len=0: no shift, stay IDLE, busy=0, done pulses one cycle next cycle.
REQ-026 SHALL ignore mode and burst_start while in BURST.
REQ-027 SHALL, with en=0, freeze Q, state, counter; done is 0 while en=0 and a pending done is emitted on the next en=1 cycle only if the final shift occurred.
REQ-028 SHALL accept burst_len > WIDTH; shifts continue, Q fills with serial input bits.

Reset
REQ-029 SHALL, on rst=1 (any time, incl. mid-burst), immediately force Q=0, state=IDLE, counter=0, busy=0, done=0.
REQ-030 SHALL resume normal operation on the first rising clk edge after rst deasserts; no burst resumes.

Verification
REQ-031 SHALL verify: rst pulse mid-burst (Q=0x3C) -> Q=0x00, busy=0, done=0 without clock edge.
REQ-032 SHALL verify: load 0xA5, mode 011 -> 0x4B, mode 100 -> 0xA5, mode 110 -> 0x00.
REQ-033 SHALL verify: Q=0x80, mode 001, ser_in_l=1 -> Q=0x01; mode 010, ser_in_r=1 from 0x01 -> 0x80; ser_out_l/ser_out_r track Q[7]/Q[0].
REQ-034 SHALL verify: Q=0x0F, burst_start, burst_len=3, dir=0, ser_in_l=0 -> Q=0x1E,0x3C,0x78 on three following edges, busy=1 for 3 cycles, done=1 for 1 cycle after.
REQ-035 SHALL verify: same burst with en=0 for 2 cycles after first shift -> Q holds 0x1E, busy stays 1, final Q=0x78, busy extends to 5 cycles, single done pulse.
REQ-036 SHALL verify: burst_len=0 with Q=0x5A -> Q stays 0x5A, busy=0, done=1 for one cycle; mode changes during BURST have no effect.
